// File: rtl/restador_serial_if.sv
// Tiny Tapeout user-module pin bundle for restador_serial.
// The master drives the switch and start inputs; the slave owns the outputs.
interface restador_serial_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/restador_serial.sv
// Bit-serial subtractor D = A - B, one full-subtractor step per clock, LSB first.
// The start switch is synchronized and edge-detected; the result is held for the display.
module restador_serial #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  restador_serial_if.slave   tt
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e                   state_q,     state_d;
  logic [SYNC_STAGES-1:0]   sync_q,      sync_d;
  logic                     sync_prev_q, sync_prev_d;
  logic [WIDTH-1:0]         a_sr_q,      a_sr_d;
  logic [WIDTH-1:0]         b_sr_q,      b_sr_d;
  logic [WIDTH-1:0]         d_sr_q,      d_sr_d;
  logic                     br_q,        br_d;
  logic [CNT_W-1:0]         cnt_q,       cnt_d;
  logic [WIDTH-1:0]         d_q,         d_d;
  logic                     borrow_q,    borrow_d;
  logic                     zero_q,      zero_d;
  logic                     busy_q,      busy_d;
  logic                     done_q,      done_d;

  logic                     start_pulse_c;
  logic                     diff_bit_c;
  logic                     borrow_nxt_c;
  logic [WIDTH-1:0]         result_c;
  logic                     unused_uio;

  // Full-subtractor cell on the current LSBs.
  assign start_pulse_c = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
  assign diff_bit_c    = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
  assign borrow_nxt_c  = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
  assign result_c      = {diff_bit_c, d_sr_q[WIDTH-1:1]};
  assign unused_uio    = &{1'b0, tt.uio_in[7:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      d_sr_q      <= '0;
      br_q        <= 1'b0;
      cnt_q       <= '0;
      d_q         <= '0;
      borrow_q    <= 1'b0;
      zero_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      sync_prev_q <= sync_prev_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      d_sr_q      <= d_sr_d;
      br_q        <= br_d;
      cnt_q       <= cnt_d;
      d_q         <= d_d;
      borrow_q    <= borrow_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and datapath; with ena low every flop keeps its value.
  always_comb begin
    state_d     = state_q;
    sync_d      = sync_q;
    sync_prev_d = sync_prev_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    d_sr_d      = d_sr_q;
    br_d        = br_q;
    cnt_d       = cnt_q;
    d_d         = d_q;
    borrow_d    = borrow_q;
    zero_d      = zero_q;
    busy_d      = busy_q;
    done_d      = done_q;

    if (ena) begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], tt.uio_in[0]};
      sync_prev_d = sync_q[SYNC_STAGES-1];

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_pulse_c) begin
            a_sr_d  = tt.ui_in[WIDTH-1:0];
            b_sr_d  = tt.ui_in[2*WIDTH-1:WIDTH];
            br_d    = 1'b0;
            cnt_d   = '0;
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          d_sr_d = result_c;
          a_sr_d = a_sr_q >> 1;
          b_sr_d = b_sr_q >> 1;
          br_d   = borrow_nxt_c;
          cnt_d  = cnt_q + CNT_W'(1);
          // Display only changes once the whole difference is resolved.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = S_DONE;
            d_d      = result_c;
            borrow_d = borrow_nxt_c;
            zero_d   = (result_c == '0);
          end
        end
        default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_SHIFT);
      done_d = (state_d == S_DONE);
    end
  end

  assign tt.uo_out  = {zero_q, done_q, busy_q, borrow_q, d_q};
  assign tt.uio_out = '0;
  assign tt.uio_oe  = '0;

endmodule

// File: tb/tb_restador_serial.sv
// Self-checking bench for restador_serial: directed cases plus random operands
// checked against plain modular arithmetic.
module tb_restador_serial;

  logic clk;
  logic rst_n;
  logic ena;
  int   checks;
  int   errors;

  logic [3:0] exp_d;
  logic       exp_borrow;

  restador_serial_if tt ();

  restador_serial #(.WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .tt    (tt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One operation: start edge, watch busy/done timing, then check the held result.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int hold,
                        input bit mut, input bit ena_gap, input bit pulse2);
    int off, busy_n, first_busy, done_off, extra_busy, exp_off;
    logic [4:0] prev;
    logic       prev_zero;
    prev      = {exp_borrow, exp_d};
    prev_zero = (exp_d == 4'd0);
    @(negedge clk);
    tt.ui_in     = {b, a};
    tt.uio_in[0] = 1'b1;
    off = -1; busy_n = 0; first_busy = -1; done_off = -1;
    for (int i = 0; i < 60 && done_off < 0; i++) begin
      @(negedge clk);
      off++;
      if (tt.uo_out[5]) begin
        busy_n++;
        if (first_busy < 0) first_busy = off;
        chk("held_result", 32'(tt.uo_out[4:0]), 32'(prev));
        chk("held_zero", 32'(tt.uo_out[7]), 32'(prev_zero));
      end
      if (busy_n > 0 && tt.uo_out[6]) done_off = off;
      tt.uio_in[0] = (off < hold - 1);
      if (pulse2 && busy_n == 1) tt.uio_in[0] = 1'b1;
      if (mut && busy_n > 0) tt.ui_in = {4'h8, 4'h1};
      ena = !(ena_gap && off >= 3 && off < 6);
    end
    ena = 1'b1;
    exp_off = ena_gap ? 9 : 6;
    chk("done_latency", 32'(done_off), 32'(exp_off));
    chk("busy_rise", 32'(first_busy), 32'd2);
    chk("busy_len", 32'(busy_n), ena_gap ? 32'd7 : 32'd4);
    extra_busy = 0;
    for (int i = 0; i < hold + 3; i++) begin
      @(negedge clk);
      off++;
      tt.uio_in[0] = (off < hold - 1);
      if (tt.uo_out[5]) extra_busy++;
    end
    chk("single_op", 32'(extra_busy), 32'd0);
    exp_d      = 4'(a - b);
    exp_borrow = (a < b);
    chk("diff", 32'(tt.uo_out[3:0]), 32'(exp_d));
    chk("borrow", 32'(tt.uo_out[4]), 32'(exp_borrow));
    chk("flags", 32'(tt.uo_out[7:5]), 32'({exp_d == 4'd0, 1'b1, 1'b0}));
    chk("uio_out", 32'(tt.uio_out), 32'd0);
    chk("uio_oe", 32'(tt.uio_oe), 32'd0);
  endtask

  initial begin
    int bn;
    checks = 0; errors = 0;
    exp_d = 4'd0; exp_borrow = 1'b0;
    rst_n = 1'b0; ena = 1'b1;
    tt.ui_in = 8'h00; tt.uio_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_uo", 32'(tt.uo_out), 32'h80);
    chk("reset_uio_oe", 32'(tt.uio_oe), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'h5, 4'h3, 1, 0, 0, 0);
    run_op(4'h3, 4'h5, 1, 0, 0, 0);
    run_op(4'h0, 4'h1, 1, 0, 0, 0);
    run_op(4'hF, 4'hF, 1, 0, 0, 0);
    run_op(4'h9, 4'h2, 20, 1, 0, 0);
    run_op(4'h6, 4'hB, 1, 0, 0, 1);
    run_op(4'h8, 4'h8, 1, 0, 0, 0);

    // Reset on the second SHIFT cycle aborts the operation.
    @(negedge clk);
    tt.ui_in = {4'h2, 4'hD};
    tt.uio_in[0] = 1'b1;
    bn = 0;
    for (int i = 0; i < 20 && bn < 2; i++) begin
      @(negedge clk);
      tt.uio_in[0] = 1'b0;
      if (tt.uo_out[5]) bn++;
    end
    chk("busy_before_reset", 32'(bn), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("abort_uo", 32'(tt.uo_out), 32'h80);
    exp_d = 4'd0; exp_borrow = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("idle_after_abort", 32'(tt.uo_out), 32'h80);

    run_op(4'h7, 4'h4, 1, 0, 0, 0);
    run_op(4'hC, 4'h4, 1, 0, 1, 0);

    for (int k = 0; k < 16; k++) begin
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
